// File: rtl/spike_train_gen.sv
// Programmable spike-train transmitter with a valid/ready config port.
// Optional spike counter output enabled by defining SPIKE_GEN_COUNT_EN.
module spike_train_gen #(
  parameter int NO_OF_NEURONS = 8,
  parameter int PERIOD_W      = 8,
  localparam int CW = (NO_OF_NEURONS > 1) ? $clog2(NO_OF_NEURONS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_enable,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CW-1:0]            cfg_chan,
  input  logic                     cfg_inhib,
  input  logic [PERIOD_W-1:0]      cfg_period,
  input  logic [PERIOD_W-1:0]      cfg_phase,
  output logic [NO_OF_NEURONS-1:0] o_excitatory,
  output logic [NO_OF_NEURONS-1:0] o_inhibitory,
  output logic                     o_active
`ifdef SPIKE_GEN_COUNT_EN
  ,
  output logic [15:0]              o_spike_count
`endif
);

  typedef enum logic {
    IDLE,
    WRITE
  } state_e;

  state_e state_q, state_d;
  logic   ready_q, ready_d;
  logic   wr_en;

  logic [CW-1:0]       hchan_q, hchan_d;
  logic                hinhib_q, hinhib_d;
  logic [PERIOD_W-1:0] hper_q, hper_d;
  logic [PERIOD_W-1:0] hph_q, hph_d;

  logic [PERIOD_W-1:0] period_q [NO_OF_NEURONS];
  logic [PERIOD_W-1:0] period_d [NO_OF_NEURONS];
  logic [PERIOD_W-1:0] cnt_q    [NO_OF_NEURONS];
  logic [PERIOD_W-1:0] cnt_d    [NO_OF_NEURONS];
  logic [NO_OF_NEURONS-1:0] inhib_q, inhib_d;

  logic [NO_OF_NEURONS-1:0] exc_q, exc_d;
  logic [NO_OF_NEURONS-1:0] inh_q, inh_d;
  logic                     active_q, active_d;

  // Config FSM: capture a beat in IDLE, write it out in WRITE
  always_comb begin
    state_d  = state_q;
    hchan_d  = hchan_q;
    hinhib_d = hinhib_q;
    hper_d   = hper_q;
    hph_d    = hph_q;
    wr_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid && ready_q) begin
          state_d  = WRITE;
          hchan_d  = cfg_chan;
          hinhib_d = cfg_inhib;
          hper_d   = cfg_period;
          hph_d    = cfg_phase;
        end
      end
      WRITE: begin
        wr_en   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // Per-channel counters, spike generation and config landing
  always_comb begin
    exc_d    = '0;
    inh_d    = '0;
    inhib_d  = inhib_q;
    active_d = 1'b0;
    for (int c = 0; c < NO_OF_NEURONS; c++) begin
      period_d[c] = period_q[c];
      cnt_d[c]    = cnt_q[c];
      if (wr_en && (hchan_q == CW'(c))) begin
        period_d[c] = hper_q;
        cnt_d[c]    = hph_q;
        inhib_d[c]  = hinhib_q;
      end else if (i_enable && (period_q[c] != '0)) begin
        if (cnt_q[c] == '0) begin
          cnt_d[c] = period_q[c] - PERIOD_W'(1);
          if (inhib_q[c]) begin
            inh_d[c] = 1'b1;
          end else begin
            exc_d[c] = 1'b1;
          end
        end else begin
          cnt_d[c] = cnt_q[c] - PERIOD_W'(1);
        end
      end
      active_d = active_d | (period_d[c] != '0);
    end
  end

  // State, holding and channel registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      hchan_q  <= '0;
      hinhib_q <= 1'b0;
      hper_q   <= '0;
      hph_q    <= '0;
      inhib_q  <= '0;
      exc_q    <= '0;
      inh_q    <= '0;
      active_q <= 1'b0;
      for (int c = 0; c < NO_OF_NEURONS; c++) begin
        period_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      hchan_q  <= hchan_d;
      hinhib_q <= hinhib_d;
      hper_q   <= hper_d;
      hph_q    <= hph_d;
      inhib_q  <= inhib_d;
      exc_q    <= exc_d;
      inh_q    <= inh_d;
      active_q <= active_d;
      for (int c = 0; c < NO_OF_NEURONS; c++) begin
        period_q[c] <= period_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
    end
  end

  assign cfg_ready    = ready_q;
  assign o_excitatory = exc_q;
  assign o_inhibitory = inh_q;
  assign o_active     = active_q;

`ifdef SPIKE_GEN_COUNT_EN
  logic [15:0] scnt_q, scnt_d;
  logic [16:0] ssum;

  // Saturating accumulation of spikes seen on the outputs
  always_comb begin
    ssum = {1'b0, scnt_q};
    for (int c = 0; c < NO_OF_NEURONS; c++) begin
      ssum = ssum + 17'(exc_q[c] | inh_q[c]);
    end
    scnt_d = (ssum > 17'h0FFFF) ? 16'hFFFF : ssum[15:0];
  end

  // Spike counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      scnt_q <= '0;
    end else begin
      scnt_q <= scnt_d;
    end
  end

  assign o_spike_count = scnt_q;
`endif

endmodule

// File: tb/tb_spike_train_gen.sv
// Directed table-driven bench for spike_train_gen.
// Uses 12 channels so out-of-range channel numbers are reachable.
module tb_spike_train_gen;

  localparam int N  = 12;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_enable = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan = '0;
  logic          cfg_inhib = 1'b0;
  logic [7:0]    cfg_period = '0;
  logic [7:0]    cfg_phase = '0;
  logic [N-1:0]  o_excitatory;
  logic [N-1:0]  o_inhibitory;
  logic          o_active;
`ifdef SPIKE_GEN_COUNT_EN
  logic [15:0]   o_spike_count;
`endif

  spike_train_gen #(
    .NO_OF_NEURONS(N),
    .PERIOD_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_enable(i_enable),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan),
    .cfg_inhib(cfg_inhib),
    .cfg_period(cfg_period),
    .cfg_phase(cfg_phase),
    .o_excitatory(o_excitatory),
    .o_inhibitory(o_inhibitory),
    .o_active(o_active)
`ifdef SPIKE_GEN_COUNT_EN
    ,
    .o_spike_count(o_spike_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          en;
    logic          val;
    logic [CW-1:0] chan;
    logic          inh;
    logic [7:0]    per;
    logic [7:0]    ph;
    logic [N-1:0]  exc;
    logic [N-1:0]  inhv;
    logic          rdy;
    logic          act;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec%0d got %0h want %0h", nm, idx, got, exp);
    end
  endtask

  task automatic w(input logic e, input logic va, input logic [CW-1:0] ch,
                   input logic ih, input logic [7:0] pe, input logic [7:0] ph,
                   input logic [N-1:0] ex, input logic [N-1:0] iv,
                   input logic rd, input logic ac);
    vec_t t;
    t.rst = 1'b0; t.en = e; t.val = va; t.chan = ch; t.inh = ih;
    t.per = pe; t.ph = ph; t.exc = ex; t.inhv = iv; t.rdy = rd; t.act = ac;
    vq.push_back(t);
  endtask

  task automatic o(input logic e, input logic [N-1:0] ex,
                   input logic [N-1:0] iv, input logic rd, input logic ac);
    w(e, 1'b0, '0, 1'b0, 8'd0, 8'd0, ex, iv, rd, ac);
  endtask

  task automatic rs();
    vec_t t;
    t.rst = 1'b1; t.en = 1'b0; t.val = 1'b0; t.chan = '0; t.inh = 1'b0;
    t.per = '0; t.ph = '0; t.exc = '0; t.inhv = '0; t.rdy = 1'b0; t.act = 1'b0;
    vq.push_back(t);
  endtask

  initial begin
    // reset held 10 cycles, then release
    for (int i = 0; i < 10; i++) rs();
    o(0, 'h000, 'h000, 1, 0);
    // ch0 exc period 4 phase 0
    w(0, 1, 0, 0, 4, 0, 'h000, 'h000, 0, 0);
    o(0, 'h000, 'h000, 1, 1);
    o(1, 'h001, 'h000, 1, 1);
    o(1, 'h000, 'h000, 1, 1);
    o(1, 'h000, 'h000, 1, 1);
    o(1, 'h000, 'h000, 1, 1);
    o(1, 'h001, 'h000, 1, 1);
    o(1, 'h000, 'h000, 1, 1);
    o(1, 'h000, 'h000, 1, 1);
    o(1, 'h000, 'h000, 1, 1);
    // ch1 exc p5 ph2, ch6 inh p3 ph0
    w(0, 1, 1, 0, 5, 2, 'h000, 'h000, 0, 1);
    o(0, 'h000, 'h000, 1, 1);
    w(0, 1, 6, 1, 3, 0, 'h000, 'h000, 0, 1);
    o(0, 'h000, 'h000, 1, 1);
    o(1, 'h001, 'h040, 1, 1);
    o(1, 'h000, 'h000, 1, 1);
    o(1, 'h002, 'h000, 1, 1);
    o(1, 'h000, 'h040, 1, 1);
    o(1, 'h001, 'h000, 1, 1);
    o(1, 'h000, 'h000, 1, 1);
    o(1, 'h000, 'h040, 1, 1);
    o(1, 'h002, 'h000, 1, 1);
    o(1, 'h001, 'h000, 1, 1);
    o(1, 'h000, 'h040, 1, 1);
    o(1, 'h000, 'h000, 1, 1);
    o(1, 'h000, 'h000, 1, 1);
    o(1, 'h003, 'h040, 1, 1);
    // valid held for 4 beats, one to channel 13
    rs();
    o(0, 'h000, 'h000, 1, 0);
    w(0, 1, 2, 0, 2, 0, 'h000, 'h000, 0, 0);
    w(0, 1, 13, 0, 1, 0, 'h000, 'h000, 1, 1);
    w(0, 1, 13, 0, 1, 0, 'h000, 'h000, 0, 1);
    w(0, 1, 3, 1, 2, 1, 'h000, 'h000, 1, 1);
    w(0, 1, 3, 1, 2, 1, 'h000, 'h000, 0, 1);
    w(0, 1, 7, 0, 1, 0, 'h000, 'h000, 1, 1);
    w(0, 1, 7, 0, 1, 0, 'h000, 'h000, 0, 1);
    w(0, 1, 7, 0, 1, 0, 'h000, 'h000, 1, 1);
    o(1, 'h084, 'h000, 1, 1);
    o(1, 'h080, 'h008, 1, 1);
    o(1, 'h084, 'h000, 1, 1);
    o(1, 'h080, 'h008, 1, 1);
    // enable dropped 7 cycles mid-train
    rs();
    o(0, 'h000, 'h000, 1, 0);
    w(0, 1, 0, 0, 4, 0, 'h000, 'h000, 0, 0);
    o(0, 'h000, 'h000, 1, 1);
    o(1, 'h001, 'h000, 1, 1);
    o(1, 'h000, 'h000, 1, 1);
    for (int i = 0; i < 7; i++) o(0, 'h000, 'h000, 1, 1);
    o(1, 'h000, 'h000, 1, 1);
    o(1, 'h000, 'h000, 1, 1);
    o(1, 'h001, 'h000, 1, 1);
    o(1, 'h000, 'h000, 1, 1);
    o(1, 'h000, 'h000, 1, 1);
    o(1, 'h000, 'h000, 1, 1);
    o(1, 'h001, 'h000, 1, 1);
    // write landing on a spiking channel, neighbour unaffected
    rs();
    o(0, 'h000, 'h000, 1, 0);
    w(0, 1, 1, 0, 1, 0, 'h000, 'h000, 0, 0);
    o(0, 'h000, 'h000, 1, 1);
    w(0, 1, 0, 0, 4, 0, 'h000, 'h000, 0, 1);
    o(0, 'h000, 'h000, 1, 1);
    o(1, 'h003, 'h000, 1, 1);
    o(1, 'h002, 'h000, 1, 1);
    o(1, 'h002, 'h000, 1, 1);
    w(1, 1, 0, 1, 2, 0, 'h002, 'h000, 0, 1);
    o(1, 'h002, 'h000, 1, 1);
    o(1, 'h002, 'h001, 1, 1);
    o(1, 'h002, 'h000, 1, 1);
    o(1, 'h002, 'h001, 1, 1);
    o(0, 'h000, 'h000, 1, 1);
    // reset while in WRITE, then period-0 rewrite
    rs();
    o(0, 'h000, 'h000, 1, 0);
    w(0, 1, 0, 0, 4, 0, 'h000, 'h000, 0, 0);
    rs();
    o(0, 'h000, 'h000, 1, 0);
    o(1, 'h000, 'h000, 1, 0);
    o(1, 'h000, 'h000, 1, 0);
    o(1, 'h000, 'h000, 1, 0);
    w(1, 1, 0, 0, 4, 0, 'h000, 'h000, 0, 0);
    o(1, 'h000, 'h000, 1, 1);
    w(1, 1, 0, 0, 0, 0, 'h001, 'h000, 0, 1);
    o(1, 'h000, 'h000, 1, 0);
    o(1, 'h000, 'h000, 1, 0);
    o(1, 'h000, 'h000, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      reset      = vq[i].rst;
      i_enable   = vq[i].en;
      cfg_valid  = vq[i].val;
      cfg_chan   = vq[i].chan;
      cfg_inhib  = vq[i].inh;
      cfg_period = vq[i].per;
      cfg_phase  = vq[i].ph;
      tick();
      chk("exc", i, 16'(o_excitatory), 16'(vq[i].exc));
      chk("inh", i, 16'(o_inhibitory), 16'(vq[i].inhv));
      chk("rdy", i, 16'(cfg_ready), 16'(vq[i].rdy));
      chk("act", i, 16'(o_active), 16'(vq[i].act));
    end

`ifdef SPIKE_GEN_COUNT_EN
    reset     = 1'b1;
    i_enable  = 1'b0;
    cfg_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("cnt_rst", 0, o_spike_count, 16'd0);
    cfg_valid  = 1'b1;
    cfg_chan   = '0;
    cfg_inhib  = 1'b0;
    cfg_period = 8'd4;
    cfg_phase  = 8'd0;
    tick();
    cfg_valid = 1'b0;
    tick();
    i_enable = 1'b1;
    repeat (100) tick();
    chk("cnt_100", 1, o_spike_count, 16'd25);
    i_enable = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
